// File: rtl/switch_pkg.sv
// switch_pkg: default parameters and address-to-port decode for switch_nport.
package switch_pkg;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    // Top pb bits of an aw-bit address (aw <= 32, pb <= 4).
    function automatic logic [3:0] port_of(input logic [31:0] addr, input int aw, input int pb);
        return 4'((addr >> (aw - pb)) & ((32'd1 << pb) - 32'd1));
    endfunction
endpackage

// File: rtl/switch_fifo.sv
// switch_fifo: synchronous first-word-fall-through FIFO, head entry always on rdata.
module switch_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        empty   = cnt_q == '0;
        full    = cnt_q == CNT_W'(DEPTH);
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = do_push ? wr_q + PTR_W'(1) : wr_q;
        rd_d    = do_pop ? rd_q + PTR_W'(1) : rd_q;
        cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        rdata   = mem_q[rd_q];
        count   = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately not reset; the count alone marks entries live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end
endmodule

// File: rtl/switch_nport.sv
// switch_nport: routes {addr,data} words by top address bits into per-port FWFT FIFOs.
module switch_nport
    import switch_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int PORT_BITS = $clog2(NUM_PORTS),
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ADDR_WIDTH-1:0]           in_addr,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic [NUM_PORTS-1:0]            out_valid,
    input  logic [NUM_PORTS-1:0]            out_ready,
    output logic [NUM_PORTS*ADDR_WIDTH-1:0] out_addr,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_PORTS*CNT_W-1:0]      level
);
    localparam int W = ADDR_WIDTH + DATA_WIDTH;

    logic [PORT_BITS-1:0] target;
    logic [NUM_PORTS-1:0] push, full, empty;

    // in_ready looks only at the registered full flag of the addressed port.
    always_comb begin
        target         = PORT_BITS'(port_of(32'(in_addr), ADDR_WIDTH, PORT_BITS));
        in_ready       = rst_n && !full[target];
        push           = '0;
        push[target]   = in_valid && in_ready;
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [W-1:0] rdata;

        switch_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[p]),
            .pop   (out_ready[p]),
            .wdata ({in_addr, in_data}),
            .rdata (rdata),
            .empty (empty[p]),
            .full  (full[p]),
            .count (level[p*CNT_W +: CNT_W])
        );

        assign out_valid[p]                          = !empty[p];
        assign out_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = empty[p] ? '0 : rdata[W-1 -: ADDR_WIDTH];
        assign out_data[p*DATA_WIDTH +: DATA_WIDTH] = empty[p] ? '0 : rdata[DATA_WIDTH-1:0];
    end
endmodule

// File: doc/switch_nport.md
# switch_nport

Parametrised N-output address-routed switch with per-port buffering and valid/ready flow control. Replaces the fixed two-way split: one ingress stream of {addr, data} words is steered by address range to one of NUM_PORTS egress ports, each fronted by a small FIFO. Per-port backpressure stalls the ingress only when the addressed port's FIFO is full. Sits between the request source and the per-bank consumers in the datapath test environment.

## Interface
- ADDR_WIDTH, 8, address width; must be ≥ PORT_BITS.
- DATA_WIDTH, 16, data width.
- NUM_PORTS, 4, egress port count; power of two, 2..16.
- FIFO_DEPTH, 4, entries per port FIFO; power of two, ≥ 2.
- Derived: PORT_BITS = $clog2(NUM_PORTS); CNT_W = $clog2(FIFO_DEPTH)+1.
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  ingress word present.
- in_ready  out  1  ingress word accepted this cycle when in_valid && in_ready.
- in_addr  in  ADDR_WIDTH  ingress address; also the routing key.
- in_data  in  DATA_WIDTH  ingress payload.
- out_valid  out  NUM_PORTS  per-port word present.
- out_ready  in  NUM_PORTS  per-port consumer accepts.
- out_addr  out  NUM_PORTS*ADDR_WIDTH  per-port address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- out_data  out  NUM_PORTS*DATA_WIDTH  per-port payload, same packing.
- level  out  NUM_PORTS*CNT_W  per-port FIFO occupancy, packed as above.

## Operation
- Routing: target port = in_addr[ADDR_WIDTH-1 -: PORT_BITS]. Equal address ranges per port, e.g. 4 ports / 8 bits: 0x00–0x3F→0, 0x40–0x7F→1, 0x80–0xBF→2, 0xC0–0xFF→3.
- in_ready = rst_n && !full[target]. It depends combinationally on in_addr; it does not depend on any out_ready. Full status uses the registered count, so a full FIFO refuses a push even when it pops in the same cycle.
- Push: on in_valid && in_ready, write {in_addr, in_data} into the target FIFO only. No other FIFO changes. Words to the same port stay in order. Words to different ports have no ordering relation.
- Pop: on out_valid[p] && out_ready[p], FIFO p advances. Ports are independent.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged and both take effect.
- Empty FIFO: push and pop cannot coincide because out_valid is low. There is no bypass path.
- out_valid[p] = (count[p] != 0).
- out_addr and out_data for port p show the head entry when out_valid[p] is high, and 0 when it is low.
- in_valid with a full target: the word is held by the source and nothing is dropped. in_ready recovers the cycle after a pop lowers the count.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- Reset, including mid-operation: every FIFO's pointers and count go to 0 and buffered contents are discarded. Storage is not cleared.

## Timing
- Reset values: in_ready=0 while rst_n=0, then 1 on the first cycle after release. out_valid=0, out_addr=0, out_data=0, level=0.
- Latency: a word accepted at edge t has out_valid=1 after edge t and is poppable at edge t+1, so minimum latency is one cycle.
- Throughput: one ingress word per cycle while the target port is not full. Each port sustains one pop per cycle.
- level[p] updates at the same edge as the push or pop that changes it.

## Structure
- Package switch_pkg holds the default parameter constants and a port_of(addr) function that returns the top PORT_BITS of the address.
- Sub-module switch_fifo is a synchronous first-word-fall-through FIFO with parameters WIDTH and DEPTH. Ports: push, pop, wdata, rdata, empty, full, count.
- The top level generates NUM_PORTS instances of switch_fifo, with WIDTH = ADDR_WIDTH+DATA_WIDTH, plus the decoder and the ready multiplexer.

## Test plan
Defaults apply throughout (4 ports, 8-bit address, depth 4).
- Reset then idle: after rst_n rises, in_ready=1, out_valid=4'b0000, level=0, out_addr=0, out_data=0.
- Routing boundaries: send addr 0x3F, 0x40, 0xBF, 0xC0 with out_ready=0. Ports 0, 1, 2, 3 each show level 1 and carry the matching addr/data one cycle later.
- Fill and stall: send 5 words to 0x10 with out_ready[0]=0. The first 4 are accepted and in_ready=0 on the 5th. Words to 0x50 are still accepted while port 0 is full. Raising out_ready[0] for one cycle accepts the 5th word on the next cycle.
- Full with simultaneous pop: port 0 holds 4 words and out_ready[0]=1 while a word to port 0 is offered. The push is refused that cycle, level drops to 3, and the push is accepted on the next cycle.
- Streaming and order: 100 random words with random per-port out_ready. Each port's output sequence equals its input subsequence, with no loss and no duplication.
- Reset mid-operation: with ports 0 and 2 partly filled, assert rst_n=0 for one cycle. All level values become 0, out_valid becomes 0, and the stale words never appear at the outputs.
